nn_layer_sequencer: RTL and testbench



---
 rtl/nn_layer_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Control FSM for one inference pass through the shared NN datapath.
// A rising edge on start launches the matmul engine once per layer, runs
// ReLU between layers (never after the last one), runs argmax after the
// final layer, then latches and holds the class index until the next pass.
// Any WAIT state that sees no done pulse for TIMEOUT_CYCLES cycles aborts
// the pass to ERROR.
//
// Ports:
//   clk            single clock
//   reset          synchronous, active-high
//   start          level input, only its rising edge is used
//   mm_start       one-cycle pulse, launches matmul for layer mm_layer
//   mm_done        matmul completion pulse
//   mm_layer       current layer index, stable for the whole layer
//   relu_start     one-cycle pulse
//   relu_done      ReLU completion pulse
//   argmax_start   one-cycle pulse
//   argmax_done    argmax completion pulse
//   argmax_value   class index, valid while argmax_done is high
//   result         latched class index (4'hF = blank after reset)
//   done           high while in DONE
//   busy           high in every state except IDLE, DONE and ERROR
//   error          high while in ERROR
//   current_state  state encoding for the LEDs
module nn_layer_sequencer #(
    parameter int NUM_LAYERS     = 3,
    parameter int LAYER_W        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               mm_start,
    input  logic               mm_done,
    output logic [LAYER_W-1:0] mm_layer,
    output logic               relu_start,
    input  logic               relu_done,
    output logic               argmax_start,
    input  logic               argmax_done,
    input  logic [3:0]         argmax_value,
    output logic [3:0]         result,
    output logic               done,
    output logic               busy,
    output logic               error,
    output logic [3:0]         current_state
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_MM_START     = 4'd1,
        S_MM_WAIT      = 4'd2,
        S_RELU_START   = 4'd3,
        S_RELU_WAIT    = 4'd4,
        S_NEXT_LAYER   = 4'd5,
        S_ARGMAX_START = 4'd6,
        S_ARGMAX_WAIT  = 4'd7,
        S_DONE         = 4'd8,
        S_ERROR        = 4'd9
    } state_t;

    // Expiry fires in the last permitted wait cycle so the exit edge lands
    // after exactly TIMEOUT_CYCLES cycles spent waiting.
    localparam logic [15:0]        WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               start_q_r;
    logic               start_edge_s;
    logic               is_wait_s;
    logic               expired_s;
    logic               last_layer_s;
    logic               idle_like_s;
    logic [15:0]        wait_cnt_r;
    logic [LAYER_W-1:0] mm_layer_r;
    logic [3:0]         result_r;
    logic               mm_start_r;
    logic               relu_start_r;
    logic               argmax_start_r;
    logic               done_r;
    logic               busy_r;
    logic               error_r;

    assign start_edge_s = start & ~start_q_r;
    assign is_wait_s    = (state_r == S_MM_WAIT) || (state_r == S_RELU_WAIT) ||
                          (state_r == S_ARGMAX_WAIT);
    assign expired_s    = (wait_cnt_r == WAIT_LIMIT);
    assign last_layer_s = (mm_layer_r == LAST_LAYER);
    assign idle_like_s  = (state_r == S_IDLE) || (state_r == S_DONE) ||
                          (state_r == S_ERROR);

    // start history; loads during reset too, so a start held through reset gives no edge
    always_ff @(posedge clk) begin
        start_q_r <= start;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a done pulse is checked before expiry so it wins a tie
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge_s) state_nxt_s = S_MM_START;
                else              state_nxt_s = state_r;
            end
            S_MM_START: state_nxt_s = S_MM_WAIT;
            S_MM_WAIT: begin
                if (mm_done) begin
                    if (last_layer_s) state_nxt_s = S_ARGMAX_START;
                    else              state_nxt_s = S_RELU_START;
                end else if (expired_s) begin
                    state_nxt_s = S_ERROR;
                end else begin
                    state_nxt_s = S_MM_WAIT;
                end
            end
            S_RELU_START: state_nxt_s = S_RELU_WAIT;
            S_RELU_WAIT: begin
                if (relu_done)      state_nxt_s = S_NEXT_LAYER;
                else if (expired_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_RELU_WAIT;
            end
            S_NEXT_LAYER:   state_nxt_s = S_MM_START;
            S_ARGMAX_START: state_nxt_s = S_ARGMAX_WAIT;
            S_ARGMAX_WAIT: begin
                if (argmax_done)    state_nxt_s = S_DONE;
                else if (expired_s) state_nxt_s = S_ERROR;
                else                state_nxt_s = S_ARGMAX_WAIT;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Wait counter, layer index and latched result
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 16'd0;
            mm_layer_r <= '0;
            result_r   <= 4'hF;
        end else begin
            // WAIT states are only entered from a START state, where the count is zero
            if (is_wait_s) wait_cnt_r <= wait_cnt_r + 16'd1;
            else           wait_cnt_r <= 16'd0;

            if (idle_like_s && start_edge_s)  mm_layer_r <= '0;
            else if (state_r == S_NEXT_LAYER) mm_layer_r <= mm_layer_r + LAYER_W'(1);
            else                              mm_layer_r <= mm_layer_r;

            if ((state_r == S_ARGMAX_WAIT) && argmax_done) result_r <= argmax_value;
            else                                           result_r <= result_r;
        end
    end

    // Moore flags registered from the next state so they line up with state_r
    always_ff @(posedge clk) begin
        if (reset) begin
            mm_start_r     <= 1'b0;
            relu_start_r   <= 1'b0;
            argmax_start_r <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            mm_start_r     <= (state_nxt_s == S_MM_START);
            relu_start_r   <= (state_nxt_s == S_RELU_START);
            argmax_start_r <= (state_nxt_s == S_ARGMAX_START);
            done_r         <= (state_nxt_s == S_DONE);
            error_r        <= (state_nxt_s == S_ERROR);
            busy_r         <= !((state_nxt_s == S_IDLE) || (state_nxt_s == S_DONE) ||
                                (state_nxt_s == S_ERROR));
        end
    end

    assign mm_start      = mm_start_r;
    assign relu_start    = relu_start_r;
    assign argmax_start  = argmax_start_r;
    assign done          = done_r;
    assign busy          = busy_r;
    assign error         = error_r;
    assign mm_layer      = mm_layer_r;
    assign result        = result_r;
    assign current_state = state_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer. Two instances share all inputs:
// dut uses the default 65535-cycle timeout, dut_to uses TIMEOUT_CYCLES=8.
// The responder in cyc() answers start pulses based on the main dut state.
module tb_nn_layer_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mm_done = 1'b0;
    logic       relu_done = 1'b0;
    logic       argmax_done = 1'b0;
    logic [3:0] argmax_value = 4'd0;

    logic       mm_start, relu_start, argmax_start, done, busy, error;
    logic [1:0] mm_layer;
    logic [3:0] result, cur_state;

    logic       t_mm_start, t_relu_start, t_argmax_start, t_done, t_busy, t_error;
    logic [1:0] t_mm_layer;
    logic [3:0] t_result, t_state;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    bit resp_en = 1'b0;
    bit relu_en = 1'b1;
    int mm_delay[4] = '{1, 1, 1, 1};
    int mm_wcnt = 0;
    int mm_pulses = 0;
    int relu_pulses = 0;
    int argmax_pulses = 0;
    logic [1:0] layer_log[$];

    nn_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .mm_start(mm_start), .mm_done(mm_done), .mm_layer(mm_layer),
        .relu_start(relu_start), .relu_done(relu_done),
        .argmax_start(argmax_start), .argmax_done(argmax_done),
        .argmax_value(argmax_value), .result(result), .done(done),
        .busy(busy), .error(error), .current_state(cur_state)
    );

    nn_layer_sequencer #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .reset(reset), .start(start),
        .mm_start(t_mm_start), .mm_done(mm_done), .mm_layer(t_mm_layer),
        .relu_start(t_relu_start), .relu_done(relu_done),
        .argmax_start(t_argmax_start), .argmax_done(argmax_done),
        .argmax_value(argmax_value), .result(t_result), .done(t_done),
        .busy(t_busy), .error(t_error), .current_state(t_state)
    );

    always #5 clk = ~clk;

    // Advance one cycle, sample #1 after the edge, log pulses, drive responses
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (mm_start === 1'b1) begin
            mm_pulses++;
            layer_log.push_back(mm_layer);
        end
        if (relu_start === 1'b1) relu_pulses++;
        if (argmax_start === 1'b1) argmax_pulses++;
        if (cur_state == 4'd2) mm_wcnt++;
        else mm_wcnt = 0;
        mm_done     = resp_en && (cur_state == 4'd2) && (mm_wcnt == mm_delay[mm_layer]);
        relu_done   = resp_en && relu_en && (cur_state == 4'd4);
        argmax_done = resp_en && (cur_state == 4'd7);
    endtask

    task automatic clear_mon();
        mm_pulses = 0;
        relu_pulses = 0;
        argmax_pulses = 0;
        layer_log.delete();
    endtask

    task automatic reset_all();
        reset = 1'b1;
        start = 1'b0;
        resp_en = 1'b0;
        relu_en = 1'b1;
        mm_delay = '{1, 1, 1, 1};
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        clear_mon();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        cyc();
        cyc();
        checks++;
        if (cur_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", cur_state); end
        checks++;
        if (result !== 4'hF) begin errors++; $display("FAIL reset_result: got %h expected f", result); end
        checks++;
        if ({mm_start, relu_start, argmax_start, done, busy, error} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {mm_start, relu_start, argmax_start, done, busy, error});
        end
        clear_mon();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (mm_pulses != 0 || cur_state !== 4'd0) begin
            errors++;
            $display("FAIL start_held_through_reset: got pulses=%0d state=%0d expected 0/0", mm_pulses, cur_state);
        end
        start = 1'b0;
        cyc();
    endtask

    task automatic run_pass(input logic [3:0] av, input int bound, output int t, output int td);
        clear_mon();
        resp_en = 1'b1;
        argmax_value = av;
        start = 1'b1;
        t = cyc_n;
        td = -1;
        for (int i = 0; i < bound && td < 0; i++) begin
            cyc();
            if (cyc_n == t + 1) start = 1'b0;
            if (done === 1'b1) td = cyc_n;
        end
        start = 1'b0;
    endtask

    task automatic test_nominal();
        int t, td;
        logic [5:0] layers;
        run_pass(4'd7, 40, t, td);
        layers = (layer_log.size() == 3) ? {layer_log[0], layer_log[1], layer_log[2]} : 6'h3F;
        checks++;
        if (td != t + 15) begin errors++; $display("FAIL nominal_latency: got %0d expected %0d", td - t, 15); end
        checks++;
        if (mm_pulses != 3 || layers !== 6'b000110) begin
            errors++; $display("FAIL nominal_mm_layers: got n=%0d seq=%b expected 3/000110", mm_pulses, layers);
        end
        checks++;
        if (relu_pulses != 2) begin errors++; $display("FAIL nominal_relu_count: got %0d expected 2", relu_pulses); end
        checks++;
        if (argmax_pulses != 1) begin errors++; $display("FAIL nominal_argmax_count: got %0d expected 1", argmax_pulses); end
        checks++;
        if (result !== 4'd7) begin errors++; $display("FAIL nominal_result: got %0d expected 7", result); end
        checks++;
        if (busy !== 1'b0 || cur_state !== 4'd8) begin
            errors++; $display("FAIL nominal_done_state: got busy=%b state=%0d expected 0/8", busy, cur_state);
        end
    endtask

    task automatic test_rerun();
        int t, td, bad;
        bit dropped;
        clear_mon();
        resp_en = 1'b1;
        argmax_value = 4'd3;
        start = 1'b1;
        t = cyc_n;
        td = -1;
        bad = 0;
        dropped = 1'b0;
        for (int i = 0; i < 40 && td < 0; i++) begin
            cyc();
            if (cyc_n == t + 1) begin
                start = 1'b0;
                dropped = (done === 1'b0) && (cur_state === 4'd1);
            end
            if (done === 1'b1) td = cyc_n;
            else if (result !== 4'd7) bad++;
        end
        checks++;
        if (!dropped) begin errors++; $display("FAIL rerun_done_drop: got done=%b state=%0d expected 0/1", done, cur_state); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rerun_result_hold: got %0d early changes expected 0", bad); end
        checks++;
        if (td != t + 15 || result !== 4'd3) begin
            errors++; $display("FAIL rerun_result: got lat=%0d result=%0d expected 15/3", td - t, result);
        end
    endtask

    task automatic test_delayed();
        int t, td, l1w;
        clear_mon();
        resp_en = 1'b1;
        mm_delay[1] = 50;
        argmax_value = 4'd5;
        start = 1'b1;
        t = cyc_n;
        td = -1;
        l1w = 0;
        for (int i = 0; i < 150 && td < 0; i++) begin
            cyc();
            if (cyc_n == t + 1) start = 1'b0;
            if (cur_state === 4'd2 && mm_layer === 2'd1) l1w++;
            if (done === 1'b1) td = cyc_n;
        end
        mm_delay[1] = 1;
        checks++;
        if (l1w != 50) begin errors++; $display("FAIL delayed_layer_hold: got %0d expected 50", l1w); end
        checks++;
        if (mm_pulses != 3 || relu_pulses != 2) begin
            errors++; $display("FAIL delayed_pulses: got mm=%0d relu=%0d expected 3/2", mm_pulses, relu_pulses);
        end
        checks++;
        if (td != t + 64 || result !== 4'd5) begin
            errors++; $display("FAIL delayed_latency: got lat=%0d result=%0d expected 64/5", td - t, result);
        end
    endtask

    task automatic test_timeout();
        int t, te;
        reset_all();
        resp_en = 1'b1;
        relu_en = 1'b0;
        start = 1'b1;
        t = cyc_n;
        te = -1;
        for (int i = 0; i < 40 && te < 0; i++) begin
            cyc();
            if (cyc_n == t + 1) start = 1'b0;
            if (t_state === 4'd9) te = cyc_n;
        end
        checks++;
        if (te != t + 12) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", te - t, 12); end
        checks++;
        if (t_error !== 1'b1 || t_busy !== 1'b0 || t_done !== 1'b0) begin
            errors++; $display("FAIL timeout_flags: got err=%b busy=%b done=%b expected 1/0/0", t_error, t_busy, t_done);
        end
        checks++;
        if (cur_state !== 4'd4 || error !== 1'b0) begin
            errors++; $display("FAIL long_timeout_waits: got state=%0d err=%b expected 4/0", cur_state, error);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (t_state !== 4'd1 || t_error !== 1'b0 || t_mm_start !== 1'b1 || t_mm_layer !== 2'd0) begin
            errors++;
            $display("FAIL error_restart: got state=%0d err=%b mm_start=%b layer=%0d expected 1/0/1/0",
                     t_state, t_error, t_mm_start, t_mm_layer);
        end
    endtask

    task automatic test_coincident(input int dly, input logic [3:0] exp_state, input string name);
        int t;
        reset_all();
        resp_en = 1'b1;
        mm_delay[0] = dly;
        start = 1'b1;
        t = cyc_n;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (cyc_n == t + 1) start = 1'b0;
        end
        checks++;
        if (t_state !== exp_state) begin
            errors++; $display("FAIL %s: got %0d expected %0d", name, t_state, exp_state);
        end
    endtask

    task automatic test_spurious();
        reset_all();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        // first MM_WAIT cycle: stray argmax_done plus a fresh start edge
        argmax_done = 1'b1;
        start = 1'b1;
        cyc();
        checks++;
        if (cur_state !== 4'd2 || result !== 4'hF || mm_start !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ignored: got state=%0d result=%h mm_start=%b expected 2/f/0",
                     cur_state, result, mm_start);
        end
        start = 1'b0;
        mm_done = 1'b1;
        cyc();
        cyc();
        cyc();
        checks++;
        if (cur_state !== 4'd4) begin errors++; $display("FAIL spurious_reach_relu_wait: got %0d expected 4", cur_state); end
        reset = 1'b1;
        cyc();
        checks++;
        if (cur_state !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_pass: got state=%0d busy=%b expected 0/0", cur_state, busy);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if (mm_start !== 1'b0 || relu_start !== 1'b0 || cur_state !== 4'd0) begin
            errors++; $display("FAIL after_reset_no_pulse: got mm=%b relu=%b state=%0d expected 0/0/0",
                               mm_start, relu_start, cur_state);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rerun();
        test_delayed();
        test_timeout();
        test_coincident(8, 4'd3, "done_beats_expiry");
        test_coincident(9, 4'd9, "expiry_without_done");
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
